adsr_envelope: RTL
==================

# adsr_envelope

Envelope generator that sits directly upstream of the `pwm` stage. It turns a held-key signal into an 8-bit attack/decay/sustain/release amplitude contour. `level_out` drives the PWM duty-cycle input and `gate_out` drives its gate, so the tone fades in and out instead of clicking. There is one instance per voice, and its rates are programmable at run time.

## Interface
- `TICK_DIV`, default 1000: clock cycles per envelope tick (≥2); all accumulator steps occur on ticks.
- `clk_in` input 1: system clock; everything is synchronous to its rising edge.
- `rst_n_in` input 1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `note_on_in` input 1: key held (level, synchronous to `clk_in`).
- `attack_rate_in` input 8: accumulator increment per tick in ATTACK; 0 means instant.
- `decay_rate_in` input 8: decrement per tick in DECAY; 0 means instant.
- `sustain_level_in` input 8: sustain amplitude; sampled live.
- `release_rate_in` input 8: decrement per tick in RELEASE; 0 means instant.
- `level_out` output 8: envelope amplitude, which is the top byte of the accumulator (feeds `pwm` `dc_in`).
- `gate_out` output 1: high whenever state ≠ IDLE (feeds `pwm` `gate_in`).
- `state_out` output 3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

## Operation
- **Internals:**
  - 16-bit accumulator `acc`; `level_out = acc[15:8]`.
  - Tick counter counts 0..TICK_DIV-1 and wraps; `tick` is high during the cycle count == TICK_DIV-1.
  - `note_q` holds the registered `note_on_in`.
  - rise = `note_on_in & ~note_q`; fall = `~note_on_in & note_q`.
  - S = {`sustain_level_in`, 8'h00}.
- **Edge-driven transitions:** these take effect on the clock edge where the edge is detected, without waiting for a tick. `acc` does not step on that cycle, even if `tick` is high.
  - On rise from any state, go to ATTACK with `acc` unchanged (retrigger is legato, no jump to 0).
  - On fall in ATTACK, DECAY or SUSTAIN, go to RELEASE.
  - On fall in IDLE or RELEASE, nothing happens.
- **Tick-driven steps:** applied on a `tick` when no rise or fall is present.
  - **ATTACK:** if rate = 0 or `acc` + rate ≥ 0xFFFF (17-bit sum), set `acc` = 0xFFFF and go to DECAY; otherwise `acc` += rate.
  - **DECAY:** if rate = 0 or `acc` ≤ S + rate (17-bit compare), set `acc` = S and go to SUSTAIN; otherwise `acc` −= rate.
  - **SUSTAIN:** `acc` = S on every cycle, not only on ticks, so `sustain_level_in` changes are tracked within 1 cycle.
  - **RELEASE:** if rate = 0 or `acc` ≤ rate, set `acc` = 0 and go to IDLE; otherwise `acc` −= rate.
  - **IDLE:** `acc` holds at 0.
- **Rate inputs:** read only on the tick that uses them; changing them mid-stage affects the next tick.
- **Sustain boundary values:**
  - `sustain_level_in` = 255 gives S = 0xFF00, so DECAY steps down from 0xFFFF and stops at 0xFF00.
  - `sustain_level_in` = 0 gives SUSTAIN at level 0 with `gate_out` still 1.
- **Reset:** asserting `rst_n_in` at any time, including mid-envelope, forces `acc`=0, state=IDLE, `note_q`=0 and tick counter=0. Outputs are then `level_out`=0, `gate_out`=0, `state_out`=0.
- **After reset release with the key held:** `note_q`=0, so a held `note_on_in` produces a rise on the first active clock and starts ATTACK.

## Timing
- All outputs are registered and are functions of state and `acc` only; there are no combinational paths from the inputs.
- Rise sampled at edge N gives `state_out`=1 and `gate_out`=1 from edge N onward (visible in cycle N+1). `level_out` first moves on the first tick after.
- Fall gives `state_out`=4 one edge after sampling. `gate_out` stays 1 until the tick that reaches 0, then drops on that same edge.
- Stage completion and the state change happen on the same edge as the final `acc` update.
- Worst-case attack is ceil(65535/rate) ticks: rate 1 takes 65535 ticks, rate 255 takes 257 ticks.
- The tick counter free-runs and is never re-phased by note events.

## Test plan
All scenarios use TICK_DIV=4.

- **Reset mid-RELEASE:** pulse `rst_n_in` low → same cycle asynchronously `level_out`=0, `gate_out`=0, `state_out`=0; tick phase restarts at 0.
- **Attack at rate 255:** rates A=255/D=16/R=32, S=128; raise `note_on_in` → `gate_out`=1 next edge; `level_out` rises 0,0,1,2,… and reaches 255 after 257 ticks (1028 cycles); state then goes 2 → 3 with `level_out` settling at 128 and never below 128.
- **Release before attack completes:** drop `note_on_in` at `acc`=0x4000 → `state_out`=4 next edge; `acc` falls by 32 per tick; `gate_out` falls on the tick where `acc` ≤ 32, leaving `acc`=0.
- **Instant rates:** A=0, D=0, S=200 → `level_out` goes 255 on the first tick and 200 on the second; R=0 → 0 and `gate_out`=0 on the first tick after the fall.
- **Retrigger during RELEASE:** rise at `acc`=0x3000 → state=1 with `acc`=0x3000 unchanged, then climbs; a rise coinciding with a tick causes no `acc` step that cycle.
- **Live sustain:** change `sustain_level_in` 128→64 while in SUSTAIN → `level_out`=64 within 1 cycle.

Source files
------------

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: turns a held-key level into an 8-bit attack/decay/sustain/release
// amplitude contour with a gate, stepped on a divided envelope tick.
module adsr_envelope #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       note_on_in,
  input  logic [7:0] attack_rate_in,
  input  logic [7:0] decay_rate_in,
  input  logic [7:0] sustain_level_in,
  input  logic [7:0] release_rate_in,
  output logic [7:0] level_out,
  output logic       gate_out,
  output logic [2:0] state_out
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic             note_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gate_q;

  logic        tick, rise, fall;
  logic [15:0] sus;
  logic [16:0] atk_sum, dec_floor;

  assign tick      = (cnt_q == CNT_MAX);
  assign rise      = note_on_in & ~note_q;
  assign fall      = ~note_on_in & note_q;
  assign sus       = {sustain_level_in, 8'h00};
  assign atk_sum   = {1'b0, acc_q} + 17'(attack_rate_in);
  assign dec_floor = {1'b0, sus} + 17'(decay_rate_in);

  // Next-state and accumulator update; key edges take priority and suppress any tick step.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (rise) begin
      state_d = ATTACK;
    end else if (fall) begin
      if (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN) begin
        state_d = RELEASE;
      end
    end else begin
      case (state_q)
        ATTACK: begin
          if (tick) begin
            if (attack_rate_in == 8'd0 || atk_sum >= 17'h0FFFF) begin
              acc_d   = 16'hFFFF;
              state_d = DECAY;
            end else begin
              acc_d = atk_sum[15:0];
            end
          end
        end
        DECAY: begin
          if (tick) begin
            if (decay_rate_in == 8'd0 || {1'b0, acc_q} <= dec_floor) begin
              acc_d   = sus;
              state_d = SUSTAIN;
            end else begin
              acc_d = acc_q - 16'(decay_rate_in);
            end
          end
        end
        SUSTAIN: acc_d = sus;
        RELEASE: begin
          if (tick) begin
            if (release_rate_in == 8'd0 || acc_q <= 16'(release_rate_in)) begin
              acc_d   = 16'h0000;
              state_d = IDLE;
            end else begin
              acc_d = acc_q - 16'(release_rate_in);
            end
          end
        end
        default: acc_d = 16'h0000;
      endcase
    end
  end

  // State, accumulator, key history and free-running tick divider.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      acc_q   <= 16'h0000;
      note_q  <= 1'b0;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      note_q  <= note_on_in;
      cnt_q   <= tick ? '0 : cnt_q + CNT_W'(1);
      gate_q  <= (state_d != IDLE);
    end
  end

  assign level_out = acc_q[15:8];
  assign gate_out  = gate_q;
  assign state_out = state_q;

endmodule
